// File: rtl/wb_stage.sv
// Write-back stage: retires instructions from the memory stage, drives the register-file
// write port and forwarding bus, executes print/exit syscalls and counts retired instructions.
module wb_stage #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned SIG_W    = 8,
    parameter int unsigned SYS_EXIT = 10,
    parameter int unsigned SYS_PINT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_ir,
    input  logic [SIG_W-1:0] in_signal,
    input  logic [4:0]       in_dst,
    input  logic [31:0]      in_r,
    input  logic [31:0]      in_mem_data,
    input  logic [31:0]      in_v0,
    input  logic [31:0]      in_a0,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             halted,
    output logic [31:0]      disp_data,
    output logic             disp_valid,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [31:0]      last_pc
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned RA_W     = 5;
    localparam int unsigned SYS_PHEX = 34;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              rf_we_q, rf_we_d;
    logic [RA_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
    logic              halted_q, halted_d;
    logic [XLEN-1:0]   disp_data_q, disp_data_d;
    logic              disp_valid_q, disp_valid_d;
    logic [CNT_W-1:0]  retired_cnt_q, retired_cnt_d;
    logic [XLEN-1:0]   last_pc_q, last_pc_d;

    logic accept_c;
    logic is_sys_c;
    logic is_exit_c;
    logic is_print_c;
    logic [XLEN-1:0] wb_value_c;

    // Instruction word and spare control bits are carried for debug only.
    logic unused_ok;
    assign unused_ok = ^{in_ir, in_signal[SIG_W-1:4]};

    assign accept_c   = (state_q == S_RUN) && in_valid;
    assign is_sys_c   = in_signal[3];
    assign is_exit_c  = is_sys_c && (in_v0 == XLEN'(SYS_EXIT));
    assign is_print_c = is_sys_c && ((in_v0 == XLEN'(SYS_PINT)) || (in_v0 == XLEN'(SYS_PHEX)));

    // Link has fixed priority over load data.
    assign wb_value_c = in_signal[2] ? (in_pc + XLEN'(4)) :
                        in_signal[1] ? in_mem_data : in_r;

    // State register and all output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_RUN;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
            halted_q      <= 1'b0;
            disp_data_q   <= '0;
            disp_valid_q  <= 1'b0;
            retired_cnt_q <= '0;
            last_pc_q     <= '0;
        end else begin
            state_q       <= state_d;
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            halted_q      <= halted_d;
            disp_data_q   <= disp_data_d;
            disp_valid_q  <= disp_valid_d;
            retired_cnt_q <= retired_cnt_d;
            last_pc_q     <= last_pc_d;
        end
    end

    // Next state: HALT is only left through reset.
    always_comb begin
        state_d = state_q;
        if (accept_c && is_exit_c) begin
            state_d = S_HALT;
        end
    end

    // Output next values.
    always_comb begin
        rf_we_d       = 1'b0;
        rf_waddr_d    = rf_waddr_q;
        rf_wdata_d    = rf_wdata_q;
        halted_d      = (state_d == S_HALT);
        disp_data_d   = disp_data_q;
        disp_valid_d  = 1'b0;
        retired_cnt_d = retired_cnt_q;
        last_pc_d     = last_pc_q;
        if (accept_c) begin
            retired_cnt_d = retired_cnt_q + CNT_W'(1);
            last_pc_d     = in_pc;
            if (is_print_c) begin
                disp_data_d  = in_a0;
                disp_valid_d = 1'b1;
            end
            if (!is_sys_c && in_signal[0] && (in_dst != RA_W'(0))) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = in_dst;
                rf_wdata_d = wb_value_c;
            end
        end
    end

    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign halted      = halted_q;
    assign disp_data   = disp_data_q;
    assign disp_valid  = disp_valid_q;
    assign retired_cnt = retired_cnt_q;
    assign last_pc     = last_pc_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: driver pushes the expected post-edge state of every
// cycle from a behavioural model; a monitor pops and compares after each rising edge.
module tb_wb_stage;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned SIG_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [31:0]      in_pc, in_ir, in_r, in_mem_data, in_v0, in_a0;
    logic [SIG_W-1:0] in_signal;
    logic [4:0]       in_dst;
    logic             rf_we, halted, disp_valid;
    logic [4:0]       rf_waddr;
    logic [31:0]      rf_wdata, disp_data, last_pc;
    logic [CNT_W-1:0] retired_cnt;

    wb_stage #(.CNT_W(CNT_W), .SIG_W(SIG_W), .SYS_EXIT(10), .SYS_PINT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pc(in_pc), .in_ir(in_ir),
        .in_signal(in_signal), .in_dst(in_dst), .in_r(in_r), .in_mem_data(in_mem_data),
        .in_v0(in_v0), .in_a0(in_a0), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .halted(halted), .disp_data(disp_data),
        .disp_valid(disp_valid), .retired_cnt(retired_cnt), .last_pc(last_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        halted;
        logic        dv;
        logic [31:0] disp;
        int unsigned cnt;
        logic [31:0] last_pc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Architectural model state
    bit          m_halted = 0;
    int unsigned m_cnt    = 0;
    logic [31:0] m_last_pc = '0, m_disp = '0, m_wdata = '0;
    logic [4:0]  m_waddr  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // One cycle: drive inputs, advance the model, queue the expected outputs.
    task automatic step(input bit rst, input bit valid, input logic [31:0] pc,
                        input logic [7:0] sig, input logic [4:0] dst, input logic [31:0] r,
                        input logic [31:0] mem, input logic [31:0] v0, input logic [31:0] a0);
        exp_t e;
        @(negedge clk);
        rst_n = ~rst; in_valid = valid; in_pc = pc; in_ir = $urandom; in_signal = sig;
        in_dst = dst; in_r = r; in_mem_data = mem; in_v0 = v0; in_a0 = a0;
        e.we = 0; e.dv = 0;
        if (rst) begin
            m_halted = 0; m_cnt = 0; m_last_pc = 0; m_disp = 0; m_wdata = 0; m_waddr = 0;
        end else if (!m_halted && valid) begin
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
            m_last_pc = pc;
            if (sig[3]) begin
                if (v0 == 1 || v0 == 34) begin m_disp = a0; e.dv = 1; end
                else if (v0 == 10) m_halted = 1;
            end else if (sig[0] && dst != 0) begin
                e.we = 1; m_waddr = dst;
                m_wdata = sig[2] ? pc + 4 : (sig[1] ? mem : r);
            end
        end
        e.waddr = m_waddr; e.wdata = m_wdata; e.halted = m_halted; e.disp = m_disp;
        e.cnt = m_cnt; e.last_pc = m_last_pc;
        exp_q.push_back(e);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rf_we", 32'(rf_we), 32'(e.we));
                chk("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
                chk("rf_wdata", rf_wdata, e.wdata);
                chk("halted", 32'(halted), 32'(e.halted));
                chk("disp_valid", 32'(disp_valid), 32'(e.dv));
                chk("disp_data", disp_data, e.disp);
                chk("retired_cnt", 32'(retired_cnt), e.cnt);
                chk("last_pc", last_pc, e.last_pc);
            end
        end
    end

    initial begin
        logic [31:0] v0;
        logic [7:0]  sig;
        int          wait_cyc;
        rst_n = 0; in_valid = 0; in_pc = 0; in_ir = 0; in_signal = 0; in_dst = 0;
        in_r = 0; in_mem_data = 0; in_v0 = 0; in_a0 = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 32'h10, 8'h01, 5'd3, 32'h55, 0, 0, 0);  // reset beats accept
        // addi, load, jal
        step(0, 1, 32'h100, 8'h01, 5'd8, 32'h1234, 0, 0, 0);
        step(0, 1, 32'h104, 8'h03, 5'd9, 32'h100, 32'hDEADBEEF, 0, 0);
        step(0, 1, 32'h400, 8'h05, 5'd31, 32'h77, 32'h99, 0, 0);
        // write to $0, bubble
        step(0, 1, 32'h404, 8'h01, 5'd0, 32'hABCD, 0, 0, 0);
        step(0, 0, 32'h408, 8'h01, 5'd4, 32'h1, 0, 0, 0);
        // print syscall with reg_write set, hex print, unknown syscall
        step(0, 1, 32'h408, 8'h09, 5'd2, 32'h5, 0, 32'd1, 32'd42);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h40C, 8'h08, 5'd2, 0, 0, 32'd34, 32'hCAFE);
        step(0, 1, 32'h410, 8'h08, 5'd2, 0, 0, 32'd7, 32'h5);
        // exit then frozen
        step(0, 1, 32'h414, 8'h09, 5'd2, 0, 0, 32'd10, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 1, 32'h500 + 32'(i*4), 8'h01, 5'd5, 32'h9, 0, 32'd1, 32'd3);
        // counter wrap
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 32'h600 + 32'(i*4), 8'h01, 5'(i + 1), 32'(i), 0, 0, 0);
        step(0, 1, 32'h700, 8'h08, 0, 0, 0, 32'd10, 0);
        step(0, 1, 32'h704, 8'h01, 5'd6, 32'h1, 0, 0, 0);
        step(1, 1, 32'h708, 8'h01, 5'd6, 32'h1, 0, 0, 0);  // reset while halted
        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            sig = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) sig[3] = 1'b0;
            case ($urandom_range(0, 7))
                0, 1:    v0 = 32'd1;
                2:       v0 = 32'd34;
                3:       v0 = ($urandom_range(0, 3) == 0) ? 32'd10 : 32'd5;
                default: v0 = $urandom;
            endcase
            step($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, $urandom,
                 sig, 5'($urandom), $urandom, $urandom, v0, $urandom);
        end

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
